// File: rtl/elevator_door_timer.sv
// Door-open timer for the elevator FSM counter_init/counter_done handshake.
// Obstruction rising edges restart the period a bounded number of times per init.
module elevator_door_timer #(
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned DOOR_TICKS = 8,
  parameter int unsigned MAX_EXTEND = 2,
  localparam int unsigned EW        = $clog2(MAX_EXTEND + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          counter_init_i,
  input  logic          obstruct_i,
  output logic          counter_done_o,
  output logic          busy_o,
  output logic [EW-1:0] extend_cnt_o,
  output logic          fault_o
);

  localparam int unsigned PW = $clog2(PRESCALE + 1);
  localparam int unsigned TW = $clog2(DOOR_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [EW-1:0] ext_q, ext_d;
  logic          fault_d;
  logic          busy_d;
  logic          done_d;
  logic          obs_q;
  logic          obs_rise;

  assign obs_rise = obstruct_i & ~obs_q;

  // Next-state, counters and registered-output precursors
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    ext_d   = ext_q;
    fault_d = fault_o;

    if (counter_init_i) begin
      state_d = RUN;
      pre_d   = PW'(PRESCALE - 1);
      tick_d  = TW'(DOOR_TICKS - 1);
      ext_d   = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (obs_rise && (ext_q < EW'(MAX_EXTEND))) begin
            pre_d  = PW'(PRESCALE - 1);
            tick_d = TW'(DOOR_TICKS - 1);
            ext_d  = ext_q + EW'(1);
          end else begin
            // Obstruction with no restarts left is flagged but does not stall the period
            if (obs_rise) begin
              fault_d = 1'b1;
            end
            if (pre_q != '0) begin
              pre_d = pre_q - PW'(1);
            end else if (tick_q != '0) begin
              pre_d  = PW'(PRESCALE - 1);
              tick_d = tick_q - TW'(1);
            end else begin
              state_d = DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      pre_q          <= '0;
      tick_q         <= '0;
      ext_q          <= '0;
      obs_q          <= 1'b0;
      fault_o        <= 1'b0;
      busy_o         <= 1'b0;
      counter_done_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      tick_q         <= tick_d;
      ext_q          <= ext_d;
      obs_q          <= obstruct_i;
      fault_o        <= fault_d;
      busy_o         <= busy_d;
      counter_done_o <= done_d;
    end
  end

  assign extend_cnt_o = ext_q;

endmodule
